// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-window target.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle, StDevAdr, StDevAck, StRAdr, StRAck, StWData, StWAck, StRData, StMAck, StWait
  } i2c_state_e;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;
  localparam logic ACK    = 1'b0;

  // 1-byte mode wraps within the low byte and keeps the upper byte at zero.
  function automatic logic [15:0] ptr_next(input logic [15:0] ptr, input bit two_byte);
    if (two_byte) return ptr + 16'd1;
    return {8'h00, ptr[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus N-sample debounce for one open-drain line,
// producing the filtered level and single-cycle rise/fall pulses.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// Oversampled I2C target translating bus transfers into register-port
// write/read strobes against an auto-incrementing 16-bit pointer.
module i2c_target_regs import i2c_pkg::*; #(
  parameter logic [6:0]  DEV_ADDR       = 7'h4C,
  parameter bit          REG_ADDR_2BYTE = 1'b0,
  parameter int unsigned FILTER_LEN     = 3
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  output logic [15:0] o_reg_addr,
  output logic [7:0]  o_reg_wdata,
  output logic        o_reg_we,
  output logic        o_reg_re,
  input  logic [7:0]  i_reg_rdata,
  output logic        o_busy
);

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(i_sys_clk), .rst(i_sys_rst), .raw(i_scl),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(i_sys_clk), .rst(i_sys_rst), .raw(i_sda),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q, addr_hi_q;
  logic [15:0] ptr_q;
  logic        adr_cnt_q, rw_q, mack_q, rd_pend_q, wr_inc_q;
  logic        start, stop, rise_ev, byte_done;

  assign start     = sda_fall & scl;
  assign stop      = sda_rise & scl;
  assign rise_ev   = scl_rise & ~start & ~stop;
  assign byte_done = (bit_cnt_q == 4'd8);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state_q <= StIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StDevAdr;
    end else if (stop) begin
      state_d = StIdle;
    end else if (scl_fall) begin
      case (state_q)
        StDevAdr: if (byte_done) state_d = (shift_q[7:1] == DEV_ADDR) ? StDevAck : StWait;
        StDevAck: state_d = (rw_q == I2C_RD) ? StRData : StRAdr;
        StRAdr:   if (byte_done) state_d = StRAck;
        StRAck:   state_d = adr_cnt_q ? StRAdr : StWData;
        StWData:  if (byte_done) state_d = StWAck;
        StWAck:   state_d = StWData;
        StRData:  if (byte_done) state_d = StMAck;
        StMAck:   state_d = (mack_q == ACK) ? StRData : StWait;
        default:  ;
      endcase
    end
  end

  // SDA only ever moves as a function of state_q, i.e. one cycle after an SCL fall.
  always_comb begin
    o_sda_oe = 1'b0;
    case (state_q)
      StDevAck, StRAck, StWAck: o_sda_oe = 1'b1;
      StRData:                  o_sda_oe = ~shift_q[7];
      default:                  ;
    endcase
    o_reg_we = (state_q == StWData) && scl_fall && byte_done;
    o_reg_re = rise_ev && (((state_q == StDevAck) && (rw_q == I2C_RD)) ||
                           ((state_q == StMAck) && (sda == ACK)));
    o_busy   = (state_q != StIdle);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_hi_q <= '0;
      ptr_q     <= '0;
      adr_cnt_q <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_inc_q  <= 1'b0;
    end else begin
      rd_pend_q <= o_reg_re;
      wr_inc_q  <= o_reg_we;
      if (start) begin
        bit_cnt_q <= '0;
        adr_cnt_q <= 1'b0;
      end else if (stop) begin
        bit_cnt_q <= '0;
      end else if (rise_ev) begin
        if (state_q inside {StDevAdr, StRAdr, StWData, StRData}) bit_cnt_q <= bit_cnt_q + 4'd1;
        if (state_q inside {StDevAdr, StRAdr, StWData}) shift_q <= {shift_q[6:0], sda};
        if (state_q == StMAck) mack_q <= sda;
      end else if (scl_fall) begin
        if (byte_done) bit_cnt_q <= '0;
        case (state_q)
          StDevAdr: if (byte_done) rw_q <= shift_q[0];
          StRAdr: begin
            if (byte_done) begin
              adr_cnt_q <= REG_ADDR_2BYTE ? ~adr_cnt_q : 1'b0;
              if (!REG_ADDR_2BYTE || adr_cnt_q) begin
                ptr_q <= {(REG_ADDR_2BYTE ? addr_hi_q : 8'h00), shift_q};
              end else begin
                addr_hi_q <= shift_q;
              end
            end
          end
          StRData: begin
            if (byte_done) ptr_q <= ptr_next(ptr_q, REG_ADDR_2BYTE);
            else           shift_q <= {shift_q[6:0], 1'b0};
          end
          default: ;
        endcase
      end
      if (wr_inc_q)  ptr_q   <= ptr_next(ptr_q, REG_ADDR_2BYTE);
      if (rd_pend_q) shift_q <= i_reg_rdata;
    end
  end

  assign o_reg_addr  = ptr_q;
  assign o_reg_wdata = shift_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C master plus a 1-cycle-latency register model.
module tb_i2c_target_regs;

  localparam int Q = 40;  // quarter SCL period in system clocks

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe, reg_we, reg_re, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'h00;
  logic        pad_sda;

  int n_vec = 0;
  int n_err = 0;
  int re_cnt = 0;
  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [7:0]  mem[256];

  assign pad_sda = sda_m & ~sda_oe;

  always #20 clk = ~clk;

  i2c_target_regs dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_scl(scl_m), .i_sda(pad_sda),
    .o_sda_oe(sda_oe), .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
    .o_reg_we(reg_we), .o_reg_re(reg_re), .i_reg_rdata(reg_rdata), .o_busy(busy)
  );

  always @(posedge clk) reg_rdata <= mem[reg_addr[7:0]];

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_cnt <= re_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic rstart_c();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    start_c();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  // glitch 1: 1-cycle SDA low while SCL high; glitch 2: 2-cycle SCL high while SCL low
  task automatic clk_bit(input logic b, input int glitch, output logic smp);
    sda_m = b;
    if (glitch == 2) begin
      wait_clk(Q / 2); scl_m = 1'b1; wait_clk(2); scl_m = 1'b0; wait_clk(Q / 2 - 2);
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b1;
    if (glitch == 1) begin
      wait_clk(Q / 2); sda_m = 1'b0; wait_clk(1); sda_m = b; wait_clk(Q / 2 - 1);
    end else begin
      wait_clk(Q);
    end
    smp = pad_sda;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch_en, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      int g;
      g = 0;
      if (glitch_en && i == 5) g = 1;
      if (glitch_en && i == 3) g = 2;
      clk_bit(b[i], g, s);
    end
    clk_bit(1'b1, 0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 0, s);
      d[i] = s;
    end
    clk_bit(mack, 0, s);
  endtask

  task automatic run_t1(input string tag);
    int wb, rb;
    logic a;
    wb = we_addr_q.size();
    rb = re_cnt;
    start_c();
    check({tag, ".busy_start"}, busy, 1);
    write_byte(8'h98, 0, a); check({tag, ".ack_dev"}, a, 0);
    write_byte(8'h1B, 0, a); check({tag, ".ack_reg"}, a, 0);
    write_byte(8'hA5, 0, a); check({tag, ".ack_data"}, a, 0);
    stop_c();
    wait_clk(10);
    check({tag, ".busy_stop"}, busy, 0);
    check({tag, ".we_count"}, we_addr_q.size() - wb, 1);
    check({tag, ".we_addr"}, we_addr_q[wb], 16'h001B);
    check({tag, ".we_data"}, we_data_q[wb], 8'hA5);
    check({tag, ".re_count"}, re_cnt - rb, 0);
    check({tag, ".ptr"}, reg_addr, 16'h001C);
  endtask

  initial begin
    int wb, rb;
    logic a;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'hC3;
    mem[8'h40] = 8'h3C;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);
    check("rst.sda_oe", sda_oe, 0);
    check("rst.we", reg_we, 0);
    check("rst.re", reg_re, 0);
    check("rst.addr", reg_addr, 0);
    check("rst.wdata", reg_wdata, 0);
    check("rst.busy", busy, 0);

    run_t1("t1");

    // Burst write wrapping the 1-byte pointer
    wb = we_addr_q.size();
    start_c();
    write_byte(8'h98, 0, a); check("t2.ack_dev", a, 0);
    write_byte(8'hFE, 0, a); check("t2.ack_reg", a, 0);
    write_byte(8'h11, 0, a); check("t2.ack_d0", a, 0);
    write_byte(8'h22, 0, a); check("t2.ack_d1", a, 0);
    write_byte(8'h33, 0, a); check("t2.ack_d2", a, 0);
    stop_c();
    wait_clk(10);
    check("t2.we_count", we_addr_q.size() - wb, 3);
    check("t2.we_addr0", we_addr_q[wb], 16'h00FE);
    check("t2.we_addr1", we_addr_q[wb + 1], 16'h00FF);
    check("t2.we_addr2", we_addr_q[wb + 2], 16'h0000);
    check("t2.we_data0", we_data_q[wb], 8'h11);
    check("t2.we_data1", we_data_q[wb + 1], 8'h22);
    check("t2.we_data2", we_data_q[wb + 2], 8'h33);
    check("t2.ptr", reg_addr, 16'h0001);

    // Random read: set pointer, repeated START, read two bytes
    wb = we_addr_q.size();
    rb = re_cnt;
    start_c();
    write_byte(8'h98, 0, a); check("t3.ack_dev_w", a, 0);
    write_byte(8'h10, 0, a); check("t3.ack_reg", a, 0);
    rstart_c();
    write_byte(8'h99, 0, a); check("t3.ack_dev_r", a, 0);
    read_byte(1'b0, d); check("t3.rd0", d, 8'h3C);
    read_byte(1'b1, d); check("t3.rd1", d, 8'hC3);
    check("t3.sda_oe_nack", sda_oe, 0);
    check("t3.busy_wait", busy, 1);
    stop_c();
    wait_clk(10);
    check("t3.busy_stop", busy, 0);
    check("t3.re_count", re_cnt - rb, 2);
    check("t3.we_count", we_addr_q.size() - wb, 0);
    check("t3.ptr", reg_addr, 16'h0012);

    // Foreign address: never ACKed, no strobes
    wb = we_addr_q.size();
    rb = re_cnt;
    start_c();
    write_byte(8'h9A, 0, a); check("t4.nack_dev", a, 1);
    write_byte(8'h55, 0, a); check("t4.nack_d0", a, 1);
    write_byte(8'hAA, 0, a); check("t4.nack_d1", a, 1);
    check("t4.busy_wait", busy, 1);
    stop_c();
    wait_clk(10);
    check("t4.busy_stop", busy, 0);
    check("t4.we_count", we_addr_q.size() - wb, 0);
    check("t4.re_count", re_cnt - rb, 0);
    check("t4.ptr", reg_addr, 16'h0012);

    // Glitches inside a data byte must be filtered out
    wb = we_addr_q.size();
    start_c();
    write_byte(8'h98, 0, a); check("t5.ack_dev", a, 0);
    write_byte(8'h30, 0, a); check("t5.ack_reg", a, 0);
    write_byte(8'h27, 1, a); check("t5.ack_data", a, 0);
    stop_c();
    wait_clk(10);
    check("t5.we_count", we_addr_q.size() - wb, 1);
    check("t5.we_addr", we_addr_q[wb], 16'h0030);
    check("t5.we_data", we_data_q[wb], 8'h27);

    // Reset while the target drives a 0 read bit
    start_c();
    write_byte(8'h98, 0, a); check("t6.ack_dev_w", a, 0);
    write_byte(8'h40, 0, a); check("t6.ack_reg", a, 0);
    rstart_c();
    write_byte(8'h99, 0, a); check("t6.ack_dev_r", a, 0);
    check("t6.driving0", sda_oe, 1);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q / 2);
    rst = 1'b1;
    wait_clk(1);
    check("t6.sda_oe_rst", sda_oe, 0);
    rst = 1'b0;
    check("t6.ptr_rst", reg_addr, 0);
    check("t6.busy_rst", busy, 0);
    wait_clk(2 * Q);
    run_t1("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
